// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline defines for stage-boundary registers.
// Holds reset/stall polarities, bubble encodings and stall-decode helper.
// Widths of the datapath are set per instance; values here are width-cast at use.
package ex_mem_stage_pkg;

  localparam logic        RstEnable  = 1'b1;
  localparam logic        Stop       = 1'b1;
  localparam logic        NoStop     = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [7:0]  NopOp      = 8'h00;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  typedef enum logic [1:0] {
    MODE_ADVANCE = 2'd0,
    MODE_BUBBLE  = 2'd1,
    MODE_HOLD    = 2'd2
  } stage_mode_e;

  // Classify an edge from this stage's stall bit and the downstream stall bit.
  function automatic stage_mode_e decode_stall(input logic here, input logic down);
    if (here == NoStop)     return MODE_ADVANCE;
    else if (down == Stop)  return MODE_HOLD;
    else                    return MODE_BUBBLE;
  endfunction

endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
// Latency: count updates on the rising edge after en.
// Backpressure: none; en is sampled every cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding at the maximum value once reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary register with flush, bubble insertion, hold and multi-cycle carry-over.
// Latency: 1 cycle EX to MEM; all outputs registered.
// Backpressure: stall[STAGE] stops capture; bubble if downstream runs, hold if it is stalled too.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 8,
  parameter int STAGE  = 3,
  parameter int CNT_W  = 2,
  parameter int EXC_W  = 32,
  parameter int PERF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [REG_AW-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [OP_W-1:0]     ex_aluop,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_reg2,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [EXC_W-1:0]    ex_excepttype,
  input  logic [DATA_W-1:0]   ex_inst_addr,
  input  logic                ex_in_delayslot,
  input  logic [2*DATA_W-1:0] hilo_tmp_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [REG_AW-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [OP_W-1:0]     mem_aluop,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_reg2,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [EXC_W-1:0]    mem_excepttype,
  output logic [DATA_W-1:0]   mem_inst_addr,
  output logic                mem_in_delayslot,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_tmp_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [PERF_W-1:0]   bubble_cnt
);

  stage_mode_e mode;
  logic        do_rst;
  logic        clear_payload;
  logic        clear_carry;
  logic        count_bubble;

  // Only our bit and the downstream bit matter; the rest of the vector is ignored.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  // Decode this edge's action; reset beats flush beats stall handling.
  always_comb begin
    mode          = decode_stall(stall[STAGE], stall[STAGE+1]);
    do_rst        = (rst == RstEnable);
    clear_payload = do_rst || flush || (mode == MODE_BUBBLE);
    clear_carry   = do_rst || flush || (mode == MODE_ADVANCE);
    count_bubble  = !do_rst && !flush && (mode == MODE_BUBBLE);
  end

  // Payload register: bubble on reset/flush/bubble, capture on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (clear_payload) begin
      mem_wd           <= REG_AW'(NOPRegAddr);
      mem_wreg         <= 1'b0;
      mem_wdata        <= DATA_W'(ZeroWord);
      mem_aluop        <= OP_W'(NopOp);
      mem_mem_addr     <= DATA_W'(ZeroWord);
      mem_reg2         <= DATA_W'(ZeroWord);
      mem_whilo        <= 1'b0;
      mem_hi           <= DATA_W'(ZeroWord);
      mem_lo           <= DATA_W'(ZeroWord);
      mem_excepttype   <= '0;
      mem_inst_addr    <= DATA_W'(ZeroWord);
      mem_in_delayslot <= 1'b0;
      mem_valid        <= 1'b0;
    end else if (mode == MODE_ADVANCE) begin
      mem_wd           <= ex_wd;
      mem_wreg         <= ex_wreg;
      mem_wdata        <= ex_wdata;
      mem_aluop        <= ex_aluop;
      mem_mem_addr     <= ex_mem_addr;
      mem_reg2         <= ex_reg2;
      mem_whilo        <= ex_whilo;
      mem_hi           <= ex_hi;
      mem_lo           <= ex_lo;
      mem_excepttype   <= ex_excepttype;
      mem_inst_addr    <= ex_inst_addr;
      mem_in_delayslot <= ex_in_delayslot;
      mem_valid        <= 1'b1;
    end
  end

  // Multi-cycle carry-over: loop back to EX on every stalled edge, drop it once EX advances.
  always_ff @(posedge clk) begin
    if (clear_carry) begin
      hilo_tmp_o <= '0;
      cnt_o      <= '0;
    end else begin
      hilo_tmp_o <= hilo_tmp_i;
      cnt_o      <= cnt_i;
    end
  end

  sat_counter #(
    .W (PERF_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (do_rst),
    .en    (count_bubble),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [31:0] ex_excepttype;
  logic [31:0] ex_inst_addr;
  logic        ex_in_delayslot;
  logic [63:0] hilo_tmp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [31:0] mem_excepttype;
  logic [31:0] mem_inst_addr;
  logic        mem_in_delayslot;
  logic        mem_valid;
  logic [63:0] hilo_tmp_o;
  logic [1:0]  cnt_o;
  logic [1:0]  bubble_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(
    .DATA_W (32), .REG_AW (5), .OP_W (8), .STAGE (3),
    .CNT_W (2), .EXC_W (32), .PERF_W (2)
  ) dut (
    .clk (clk), .rst (rst), .stall (stall), .flush (flush),
    .ex_wd (ex_wd), .ex_wreg (ex_wreg), .ex_wdata (ex_wdata), .ex_aluop (ex_aluop),
    .ex_mem_addr (ex_mem_addr), .ex_reg2 (ex_reg2), .ex_whilo (ex_whilo),
    .ex_hi (ex_hi), .ex_lo (ex_lo), .ex_excepttype (ex_excepttype),
    .ex_inst_addr (ex_inst_addr), .ex_in_delayslot (ex_in_delayslot),
    .hilo_tmp_i (hilo_tmp_i), .cnt_i (cnt_i),
    .mem_wd (mem_wd), .mem_wreg (mem_wreg), .mem_wdata (mem_wdata), .mem_aluop (mem_aluop),
    .mem_mem_addr (mem_mem_addr), .mem_reg2 (mem_reg2), .mem_whilo (mem_whilo),
    .mem_hi (mem_hi), .mem_lo (mem_lo), .mem_excepttype (mem_excepttype),
    .mem_inst_addr (mem_inst_addr), .mem_in_delayslot (mem_in_delayslot),
    .mem_valid (mem_valid), .hilo_tmp_o (hilo_tmp_o), .cnt_o (cnt_o),
    .bubble_cnt (bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] wd, input logic [31:0] wdata, input logic [7:0] op,
                           input logic [31:0] pc);
    ex_wd = wd; ex_wreg = 1'b1; ex_wdata = wdata; ex_aluop = op;
    ex_mem_addr = wdata ^ 32'h0000_FFFF; ex_reg2 = 32'h5555_0000 | {27'd0, wd};
    ex_whilo = 1'b1; ex_hi = 32'h0000_1111; ex_lo = 32'h0000_2222;
    ex_excepttype = 32'h0000_0100; ex_inst_addr = pc; ex_in_delayslot = 1'b1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_wd"}, 64'(mem_wd), 64'd0);
    chk({tag, "_wreg"}, 64'(mem_wreg), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_aluop"}, 64'(mem_aluop), 64'd0);
    chk({tag, "_addr"}, 64'(mem_mem_addr), 64'd0);
    chk({tag, "_reg2"}, 64'(mem_reg2), 64'd0);
    chk({tag, "_whilo"}, 64'(mem_whilo), 64'd0);
    chk({tag, "_hi"}, 64'(mem_hi), 64'd0);
    chk({tag, "_lo"}, 64'(mem_lo), 64'd0);
    chk({tag, "_exc"}, 64'(mem_excepttype), 64'd0);
    chk({tag, "_pc"}, 64'(mem_inst_addr), 64'd0);
    chk({tag, "_ds"}, 64'(mem_in_delayslot), 64'd0);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd0);
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1; flush = 1'($urandom); stall = 6'($urandom);
    ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom; ex_aluop = 8'($urandom);
    ex_mem_addr = $urandom; ex_reg2 = $urandom; ex_whilo = 1'($urandom);
    ex_hi = $urandom; ex_lo = $urandom; ex_excepttype = $urandom; ex_inst_addr = $urandom;
    ex_in_delayslot = 1'($urandom); hilo_tmp_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
    tick(); tick();
    chk_bubble("rst");
    chk("rst_hilo", hilo_tmp_o, 64'd0);
    chk("rst_cnt", 64'(cnt_o), 64'd0);
    chk("rst_bcnt", 64'(bubble_cnt), 64'd0);

    // Advance
    rst = 1'b0; flush = 1'b0; stall = 6'b000000; cnt_i = 2'd3; hilo_tmp_i = 64'h99;
    set_instr(5'd7, 32'hDEADBEEF, 8'h21, 32'hBFC0_0010);
    tick();
    chk("adv_wd", 64'(mem_wd), 64'd7);
    chk("adv_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("adv_wreg", 64'(mem_wreg), 64'd1);
    chk("adv_aluop", 64'(mem_aluop), 64'h21);
    chk("adv_addr", 64'(mem_mem_addr), 64'hDEAD4110);
    chk("adv_reg2", 64'(mem_reg2), 64'h55550007);
    chk("adv_hi", 64'(mem_hi), 64'h1111);
    chk("adv_lo", 64'(mem_lo), 64'h2222);
    chk("adv_exc", 64'(mem_excepttype), 64'h100);
    chk("adv_pc", 64'(mem_inst_addr), 64'hBFC00010);
    chk("adv_ds", 64'(mem_in_delayslot), 64'd1);
    chk("adv_valid", 64'(mem_valid), 64'd1);
    chk("adv_cnt", 64'(cnt_o), 64'd0);
    chk("adv_hilo", hilo_tmp_o, 64'd0);

    // Bubble: this stage stalled, MEM runs
    stall = 6'b001111; cnt_i = 2'd2; hilo_tmp_i = 64'hAA;
    tick();
    chk_bubble("bub");
    chk("bub_bcnt", 64'(bubble_cnt), 64'd1);
    chk("bub_cnt", 64'(cnt_o), 64'd2);
    chk("bub_hilo", hilo_tmp_o, 64'hAA);

    // New instruction in, stall bits outside STAGE/STAGE+1 set but ignored
    stall = 6'b100111;
    set_instr(5'd9, 32'h1111_2222, 8'h18, 32'hBFC0_0014);
    tick();
    chk("adv2_wd", 64'(mem_wd), 64'd9);
    chk("adv2_valid", 64'(mem_valid), 64'd1);
    chk("adv2_cnt", 64'(cnt_o), 64'd0);

    // Hold for 3 cycles with carry-over; EX inputs change but must not be captured
    stall = 6'b011111; cnt_i = 2'd1; hilo_tmp_i = 64'h1234;
    set_instr(5'd12, 32'hCAFE_F00D, 8'h33, 32'hBFC0_0018);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_wd", 64'(mem_wd), 64'd9);
      chk("hold_wdata", 64'(mem_wdata), 64'h11112222);
      chk("hold_aluop", 64'(mem_aluop), 64'h18);
      chk("hold_valid", 64'(mem_valid), 64'd1);
      chk("hold_cnt", 64'(cnt_o), 64'd1);
      chk("hold_hilo", hilo_tmp_o, 64'h1234);
      chk("hold_bcnt", 64'(bubble_cnt), 64'd1);
    end
    stall = 6'b000000;
    tick();
    chk("rel_cnt", 64'(cnt_o), 64'd0);
    chk("rel_hilo", hilo_tmp_o, 64'd0);
    chk("rel_wd", 64'(mem_wd), 64'd12);
    chk("rel_wdata", 64'(mem_wdata), 64'hCAFEF00D);

    // Flush beats a bubble stall and is not counted
    flush = 1'b1; stall = 6'b001111; cnt_i = 2'd3; hilo_tmp_i = 64'h77;
    tick();
    chk_bubble("flush");
    chk("flush_bcnt", 64'(bubble_cnt), 64'd1);
    chk("flush_cnt", 64'(cnt_o), 64'd0);
    chk("flush_hilo", hilo_tmp_o, 64'd0);

    // Saturation: five bubbles from count 1 -> 2,3,3,3,3
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_bcnt", 64'(bubble_cnt), (i == 0) ? 64'd2 : 64'd3);
      chk("sat_valid", 64'(mem_valid), 64'd0);
    end

    // Reset mid multi-cycle sequence clears carry-over and counter
    stall = 6'b000000;
    tick();
    stall = 6'b011000; cnt_i = 2'd2; hilo_tmp_i = 64'h5678;
    tick();
    chk("mc_cnt", 64'(cnt_o), 64'd2);
    chk("mc_valid", 64'(mem_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("mcrst_cnt", 64'(cnt_o), 64'd0);
    chk("mcrst_hilo", hilo_tmp_o, 64'd0);
    chk("mcrst_bcnt", 64'(bubble_cnt), 64'd0);
    chk("mcrst_valid", 64'(mem_valid), 64'd0);
    chk("mcrst_wd", 64'(mem_wd), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline boundary register, successor to the fixed-width stall-only stage. It registers execute-stage results for the memory stage and adds five capabilities:
- flush;
- NOP bubble insertion when EX is stalled and MEM runs;
- a carry-over path for multi-cycle EX operations (madd/msub/div iteration state);
- exception and delay-slot fields;
- a saturating bubble counter.

Stall-bit positions and all widths are parameters, so the same block serves any stage boundary of the 6-stage stall vector.

## Interface
Parameters:
- DATA_W, 32, datapath width (wdata, mem_addr, reg2, hi, lo, inst_addr)
- REG_AW, 5, register-file address width
- OP_W, 8, ALU op code width; NOP op is all-zero
- STAGE, 3, index of this stage's bit in stall; STAGE+1 is the downstream bit; legal range 0..4
- CNT_W, 2, multi-cycle iteration counter width
- EXC_W, 32, exception-type vector width
- PERF_W, 16, bubble counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector, 1 = stop
- flush  in  1  exception flush, synchronous
- ex_wd / mem_wd  in / out  REG_AW  destination register
- ex_wreg / mem_wreg  in / out  1  register write enable
- ex_wdata / mem_wdata  in / out  DATA_W  write-back data
- ex_aluop / mem_aluop  in / out  OP_W  ALU op
- ex_mem_addr / mem_mem_addr  in / out  DATA_W  load/store address
- ex_reg2 / mem_reg2  in / out  DATA_W  store data
- ex_whilo / mem_whilo  in / out  1  HI/LO write enable
- ex_hi, ex_lo / mem_hi, mem_lo  in / out  DATA_W each  HI/LO values
- ex_excepttype / mem_excepttype  in / out  EXC_W  exception flags
- ex_inst_addr / mem_inst_addr  in / out  DATA_W  instruction PC
- ex_in_delayslot / mem_in_delayslot  in / out  1  delay-slot flag
- mem_valid  out  1  stage holds a real instruction, not a bubble
- hilo_tmp_i / hilo_tmp_o  in / out  2*DATA_W  multi-cycle partial result
- cnt_i / cnt_o  in / out  CNT_W  multi-cycle iteration count
- bubble_cnt  out  PERF_W  bubbles inserted since reset, saturating

## Operation
The following priority is evaluated once per rising edge. "Bubble values" means every payload output zero, including mem_wreg = 0, mem_whilo = 0 and mem_aluop = NOP.
- rst: all outputs zero, including mem_valid, hilo_tmp_o, cnt_o and bubble_cnt.
- flush (rst low): payload set to bubble values; mem_valid = 0; hilo_tmp_o and cnt_o = 0; bubble_cnt unchanged.
- stall[STAGE]=1, stall[STAGE+1]=0 (bubble):
  - payload set to bubble values; mem_valid = 0;
  - hilo_tmp_o <= hilo_tmp_i; cnt_o <= cnt_i;
  - bubble_cnt increments unless all-ones.
- stall[STAGE]=1, stall[STAGE+1]=1 (hold):
  - payload and mem_valid hold;
  - hilo_tmp_o <= hilo_tmp_i; cnt_o <= cnt_i.
- stall[STAGE]=0 (advance):
  - every mem_* output <= its ex_* input; mem_valid = 1;
  - hilo_tmp_o and cnt_o = 0, ending the multi-cycle sequence.
- Stall bits other than STAGE and STAGE+1 are ignored.
- No arithmetic except bubble_cnt (+1, saturating at 2^PERF_W-1, never wraps).

## Timing
- Latency: 1 cycle, EX input to MEM output. No combinational path from input to output.
- Outputs change only on a rising edge.
- Reset mid-operation, including mid multi-cycle sequence: all state clears on the same edge; the carry-over is lost.
- flush and stall asserted together: flush wins, and bubble_cnt does not count the cycle.
- Carry-over is captured on every stalled edge, so the first advancing edge after N stalled cycles clears it. EX sees hilo_tmp_o/cnt_o for iteration k+1 one cycle after presenting iteration k.
- Hold preserves the payload indefinitely; a bubble replaces it immediately.

## Structure
- Shared defines package holds RstEnable, Stop/NoStop, ZeroWord, NOP op code and NOPRegAddr; widths derive from parameters.
- One natural sub-module: `sat_counter` (PERF_W, enable, synchronous reset), reused by other stages' perf counters.
- Everything else is a flat registered block.

## Test plan
1. Reset: rst=1 for 2 cycles with random inputs -> every output 0, mem_aluop = 8'h00, bubble_cnt = 0.
2. Advance: stall = 0, ex_wd = 5'd7, ex_wreg = 1, ex_wdata = 32'hDEADBEEF -> next cycle mem_wd = 7, mem_wdata = 32'hDEADBEEF, mem_valid = 1.
3. Bubble: with a valid instruction in the stage, stall = 6'b001111 -> next cycle mem_wreg = 0, mem_aluop = 0, mem_valid = 0, bubble_cnt = 1.
4. Hold plus carry-over:
   - stall = 6'b011111 for 3 cycles, cnt_i = 1, hilo_tmp_i = 64'h1234 -> payload unchanged; cnt_o = 1; hilo_tmp_o = 64'h1234.
   - Then stall = 0 -> cnt_o = 0.
5. Flush priority: flush = 1 with stall = 6'b001111 -> bubble values, mem_valid = 0, bubble_cnt not incremented.
6. Saturation: PERF_W = 2, 5 consecutive bubbles -> bubble_cnt = 3, stays 3.
